// File: rtl/register_file.sv
// 32-entry register file with two combinational read ports, one write port,
// and A/B latches that capture both read ports on every clock edge.
module register_file #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(32'h0000_3FFC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regWrite,
  input  logic [4:0]       readReg1,
  input  logic [4:0]       readReg2,
  input  logic [4:0]       writeReg,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B
);

  localparam logic [4:0] SP_IDX = 5'd29;

  logic [WIDTH-1:0] regs [32];
  logic             wr_en;

  assign wr_en = regWrite && (writeReg != 5'd0);

  // No bypass: a same-cycle write is only visible after the edge.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (readReg1 != 5'd0) readData1 = regs[readReg1];
    if (readReg2 != 5'd0) readData2 = regs[readReg2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[SP_IDX] <= SP_INIT;
    end else if (wr_en) begin
      regs[writeReg] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A <= '0;
      B <= '0;
    end else begin
      A <= readData1;
      B <= readData2;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected port values
// tagged with a cycle; a negedge monitor pops and compares them.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] A;
  logic [31:0] B;

  register_file dut (
    .clk(clk),
    .reset(reset),
    .regWrite(regWrite),
    .readReg1(readReg1),
    .readReg2(readReg2),
    .writeReg(writeReg),
    .writeData(writeData),
    .readData1(readData1),
    .readData2(readData2),
    .A(A),
    .B(B)
  );

  always #5 clk = ~clk;

  typedef enum int { F_RD1, F_RD2, F_A, F_B } field_e;

  typedef struct {
    string       name;
    int          cyc;
    field_e      fld;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc++;

  task automatic expect_v(input string n, input field_e f,
                          input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.cyc  = cyc;
    e.fld  = f;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.fld)
        F_RD1: act = readData1;
        F_RD2: act = readData2;
        F_A:   act = A;
        default: act = B;
      endcase
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: stale check cycle %0d at %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v1, v2, p1, p2;
    reset     = 1'b1;
    regWrite  = 1'b0;
    readReg1  = 5'd0;
    readReg2  = 5'd0;
    writeReg  = 5'd0;
    writeData = '0;

    // reset edge, then read $sp and an ordinary register
    step();
    reset    = 1'b0;
    readReg1 = 5'd29;
    readReg2 = 5'd5;
    expect_v("rst_sp", F_RD1, 32'h0000_3FFC);
    expect_v("rst_r5", F_RD2, 32'h0);
    expect_v("rst_A", F_A, 32'h0);
    expect_v("rst_B", F_B, 32'h0);

    // write 8 then read it back, A one edge later
    step();
    regWrite  = 1'b1;
    writeReg  = 5'd8;
    writeData = 32'hDEAD_BEEF;
    readReg1  = 5'd8;
    expect_v("wr8_pre", F_RD1, 32'h0);
    step();
    regWrite = 1'b0;
    expect_v("wr8_rd1", F_RD1, 32'hDEAD_BEEF);
    expect_v("wr8_A_old", F_A, 32'h0);
    step();
    expect_v("wr8_A", F_A, 32'hDEAD_BEEF);

    // writes to r0 are dropped
    step();
    regWrite  = 1'b1;
    writeReg  = 5'd0;
    writeData = 32'hFFFF_FFFF;
    readReg1  = 5'd0;
    readReg2  = 5'd0;
    expect_v("r0_rd1_pre", F_RD1, 32'h0);
    step();
    regWrite = 1'b0;
    expect_v("r0_rd1", F_RD1, 32'h0);
    expect_v("r0_rd2", F_RD2, 32'h0);
    expect_v("r0_A", F_A, 32'h0);
    expect_v("r0_B", F_B, 32'h0);
    step();
    expect_v("r0_A2", F_A, 32'h0);
    expect_v("r0_B2", F_B, 32'h0);

    // same-cycle read/write of r9: old value until after the edge
    step();
    regWrite  = 1'b1;
    writeReg  = 5'd9;
    writeData = 32'h1;
    step();
    writeData = 32'h2;
    readReg2  = 5'd9;
    expect_v("r9_rd2_old", F_RD2, 32'h1);
    step();
    regWrite = 1'b0;
    expect_v("r9_B_old", F_B, 32'h1);
    expect_v("r9_rd2_new", F_RD2, 32'h2);
    step();
    expect_v("r9_B_new", F_B, 32'h2);

    // reset beats a pending write to $sp and clears r8
    step();
    reset     = 1'b1;
    regWrite  = 1'b1;
    writeReg  = 5'd29;
    writeData = 32'h0;
    step();
    reset    = 1'b0;
    regWrite = 1'b0;
    readReg1 = 5'd29;
    readReg2 = 5'd8;
    expect_v("rp_sp", F_RD1, 32'h0000_3FFC);
    expect_v("rp_r8", F_RD2, 32'h0);
    expect_v("rp_A", F_A, 32'h0);
    expect_v("rp_B", F_B, 32'h0);

    // first write after reset release lands normally
    step();
    regWrite  = 1'b1;
    writeReg  = 5'd29;
    writeData = 32'h0000_1234;
    step();
    regWrite = 1'b0;
    expect_v("post_rst_wr", F_RD1, 32'h0000_1234);

    // fill r1..r31, then sweep both ports with writes disabled
    for (int i = 1; i < 32; i++) begin
      step();
      regWrite  = 1'b1;
      writeReg  = 5'(i);
      writeData = 32'hA5A5_0000 + 32'(i);
    end
    step();
    regWrite  = 1'b0;
    writeReg  = 5'd3;
    writeData = 32'hBAD0_BAD0;
    p1 = 32'h0;
    p2 = 32'h0;
    for (int i = 0; i < 32; i++) begin
      step();
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      v1 = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
      v2 = (i == 31) ? 32'h0 : 32'hA5A5_0000 + 32'(31 - i);
      expect_v($sformatf("sweep_rd1_%0d", i), F_RD1, v1);
      expect_v($sformatf("sweep_rd2_%0d", 31 - i), F_RD2, v2);
      if (i > 0) begin
        expect_v($sformatf("sweep_A_%0d", i - 1), F_A, p1);
        expect_v($sformatf("sweep_B_%0d", 32 - i), F_B, p2);
      end
      p1 = v1;
      p2 = v2;
    end
    step();
    expect_v("sweep_A_31", F_A, p1);
    expect_v("sweep_B_0", F_B, p2);

    for (int k = 0; k < 5 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      bad += q.size();
      $display("FAIL drain: %0d checks never ran, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
